// File: rtl/hba_gpio_ext_pkg.sv
// hba_gpio_ext_pkg
//   Shared definitions for the HBA GPIO peripheral: register indices, the register count
//   and the decoded write-strobe bundle used by the top-level register file.
package hba_gpio_ext_pkg;

  // Register indices within the peripheral slot (hba_abus[REG_ADDR_WIDTH-1:0]).
  localparam int unsigned REG_DIR         = 0;
  localparam int unsigned REG_PINS        = 1;
  localparam int unsigned REG_INTR_EN     = 2;
  localparam int unsigned REG_EDGE_RISE   = 3;
  localparam int unsigned REG_EDGE_FALL   = 4;
  localparam int unsigned REG_INTR_STATUS = 5;
  localparam int unsigned REG_DEBOUNCE    = 6;
  localparam int unsigned REG_COUNT       = 7;

  // One write strobe per implemented register, asserted on the commit edge.
  typedef struct packed {
    logic dir;
    logic pins;
    logic intr_en;
    logic edge_rise;
    logic edge_fall;
    logic intr_status;
    logic debounce;
  } reg_wr_t;

endpackage

// File: rtl/hba_gpio_ext_pin_filter.sv
// hba_pin_filter
//   One GPIO pin's input conditioning: two-flop synchroniser, debounce counter, filtered
//   level and its one-cycle-delayed copy for edge detection.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_pin           raw asynchronous pad input
//   i_debounce      debounce threshold (cycles of disagreement before the level is taken)
//   o_filt          debounced level
//   o_rise, o_fall  single-cycle edge pulses on o_filt
module hba_pin_filter #(
  parameter int unsigned DEB_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pin,
  input  logic [DEB_WIDTH-1:0] i_debounce,
  output logic                 o_filt,
  output logic                 o_rise,
  output logic                 o_fall
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_filt;
  logic                 r_filt_prev;
  logic [DEB_WIDTH-1:0] r_cnt;

  logic                 w_filt_d;
  logic [DEB_WIDTH-1:0] w_cnt_d;

  // Counter measures how long sync2 has disagreed with filt. The >= compare means a
  // threshold lowered mid-count releases at once rather than waiting for a wrap.
  always_comb begin
    w_filt_d = r_filt;
    w_cnt_d  = '0;
    if (r_sync2 != r_filt) begin
      if (r_cnt >= i_debounce) begin
        w_filt_d = r_sync2;
      end else if (r_cnt != {DEB_WIDTH{1'b1}}) begin
        w_cnt_d = r_cnt + DEB_WIDTH'(1);
      end else begin
        w_cnt_d = r_cnt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_filt      <= 1'b0;
      r_filt_prev <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_sync1     <= i_pin;
      r_sync2     <= r_sync1;
      r_filt      <= w_filt_d;
      r_filt_prev <= r_filt;
      r_cnt       <= w_cnt_d;
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_filt & ~r_filt_prev;
  assign o_fall = ~r_filt & r_filt_prev;

endmodule

// File: rtl/hba_gpio_ext.sv
// hba_gpio_ext
//   HBA-bus GPIO peripheral: per-pin direction and output latch, debounced inputs, and
//   rising/falling edge capture into a sticky write-1-to-clear interrupt status register.
// Ports:
//   hba_clk, hba_reset_n        clock, asynchronous active-low reset
//   hba_rnw, hba_select         transfer direction (1=read) and transfer-in-progress
//   hba_abus, hba_dbus          address {periph, reg index} and write data
//   hba_dbus_slave              read data, 0 whenever not acking
//   hba_xferack_slave           one-cycle transfer acknowledge
//   slave_interrupt             |(INTR_STATUS & INTR_EN)
//   gpio_out_en, gpio_out_sig   pad drive enable (DIR) and output value (PINS latch)
//   gpio_in_sig                 raw asynchronous pad inputs
module hba_gpio_ext
  import hba_gpio_ext_pkg::*;
#(
  parameter int unsigned DBUS_WIDTH        = 8,
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int unsigned PERIPH_ADDR       = 0,
  parameter int unsigned NUM_PINS          = 4,
  parameter int unsigned DEB_WIDTH         = 8
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  output logic [NUM_PINS-1:0]   gpio_out_en,
  output logic [NUM_PINS-1:0]   gpio_out_sig,
  input  logic [NUM_PINS-1:0]   gpio_in_sig
);

  logic [NUM_PINS-1:0]   r_dir;
  logic [NUM_PINS-1:0]   r_pins;
  logic [NUM_PINS-1:0]   r_intr_en;
  logic [NUM_PINS-1:0]   r_edge_rise;
  logic [NUM_PINS-1:0]   r_edge_fall;
  logic [NUM_PINS-1:0]   r_intr_status;
  logic [DEB_WIDTH-1:0]  r_debounce;
  logic                  r_xferack;
  logic [DBUS_WIDTH-1:0] r_dbus_slave;

  logic [REG_ADDR_WIDTH-1:0] w_reg_idx;
  logic                      w_periph_hit;
  logic                      w_req;
  reg_wr_t                   w_wr;
  logic [DBUS_WIDTH-1:0]     w_rdata;
  logic [NUM_PINS-1:0]       w_filt;
  logic [NUM_PINS-1:0]       w_rise;
  logic [NUM_PINS-1:0]       w_fall;
  logic [NUM_PINS-1:0]       w_status_set;
  logic [NUM_PINS-1:0]       w_status_clr;
  logic                      w_unused_dbus;

  // Upper write-data bits only matter for wider registers; fold them so none dangle.
  assign w_unused_dbus = ^hba_dbus;

  // ---------------------------------------------------------------------------------------
  // Bus decode. A request is only taken while not already acking, which limits throughput
  // to one transfer every two cycles and keeps a held select from double-committing.
  // ---------------------------------------------------------------------------------------
  assign w_reg_idx    = hba_abus[REG_ADDR_WIDTH-1:0];
  assign w_periph_hit = (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]
                         == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign w_req        = hba_select & w_periph_hit & ~r_xferack;

  always_comb begin
    w_wr = '0;
    if (w_req && !hba_rnw) begin
      case (w_reg_idx)
        REG_ADDR_WIDTH'(REG_DIR):         w_wr.dir         = 1'b1;
        REG_ADDR_WIDTH'(REG_PINS):        w_wr.pins        = 1'b1;
        REG_ADDR_WIDTH'(REG_INTR_EN):     w_wr.intr_en     = 1'b1;
        REG_ADDR_WIDTH'(REG_EDGE_RISE):   w_wr.edge_rise   = 1'b1;
        REG_ADDR_WIDTH'(REG_EDGE_FALL):   w_wr.edge_fall   = 1'b1;
        REG_ADDR_WIDTH'(REG_INTR_STATUS): w_wr.intr_status = 1'b1;
        REG_ADDR_WIDTH'(REG_DEBOUNCE):    w_wr.debounce    = 1'b1;
        default:                          w_wr             = '0;
      endcase
    end
  end

  // Read mux; PINS shows the latch on outputs and the debounced pad on inputs.
  always_comb begin
    w_rdata = '0;
    case (w_reg_idx)
      REG_ADDR_WIDTH'(REG_DIR):         w_rdata[NUM_PINS-1:0]  = r_dir;
      REG_ADDR_WIDTH'(REG_PINS):        w_rdata[NUM_PINS-1:0]  = (r_dir & r_pins) |
                                                                 (~r_dir & w_filt);
      REG_ADDR_WIDTH'(REG_INTR_EN):     w_rdata[NUM_PINS-1:0]  = r_intr_en;
      REG_ADDR_WIDTH'(REG_EDGE_RISE):   w_rdata[NUM_PINS-1:0]  = r_edge_rise;
      REG_ADDR_WIDTH'(REG_EDGE_FALL):   w_rdata[NUM_PINS-1:0]  = r_edge_fall;
      REG_ADDR_WIDTH'(REG_INTR_STATUS): w_rdata[NUM_PINS-1:0]  = r_intr_status;
      REG_ADDR_WIDTH'(REG_DEBOUNCE):    w_rdata[DEB_WIDTH-1:0] = r_debounce;
      default:                          w_rdata                = '0;
    endcase
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_xferack    <= 1'b0;
      r_dbus_slave <= '0;
    end else if (w_req) begin
      r_xferack    <= 1'b1;
      r_dbus_slave <= hba_rnw ? w_rdata : '0;
    end else begin
      r_xferack    <= 1'b0;
      r_dbus_slave <= '0;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_dir       <= '0;
      r_pins      <= '0;
      r_intr_en   <= '0;
      r_edge_rise <= '0;
      r_edge_fall <= '0;
      r_debounce  <= '0;
    end else begin
      if (w_wr.dir)       r_dir       <= hba_dbus[NUM_PINS-1:0];
      if (w_wr.pins)      r_pins      <= hba_dbus[NUM_PINS-1:0];
      if (w_wr.intr_en)   r_intr_en   <= hba_dbus[NUM_PINS-1:0];
      if (w_wr.edge_rise) r_edge_rise <= hba_dbus[NUM_PINS-1:0];
      if (w_wr.edge_fall) r_edge_fall <= hba_dbus[NUM_PINS-1:0];
      if (w_wr.debounce)  r_debounce  <= hba_dbus[DEB_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Per-pin filters and edge capture
  // ---------------------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    hba_pin_filter #(
      .DEB_WIDTH (DEB_WIDTH)
    ) u_filter (
      .i_clk      (hba_clk),
      .i_rst_n    (hba_reset_n),
      .i_pin      (gpio_in_sig[g]),
      .i_debounce (r_debounce),
      .o_filt     (w_filt[g]),
      .o_rise     (w_rise[g]),
      .o_fall     (w_fall[g])
    );
  end

  // Outputs never raise status; a fresh edge beats a same-cycle W1C of that bit.
  assign w_status_set = ~r_dir & ((w_rise & r_edge_rise) | (w_fall & r_edge_fall));
  assign w_status_clr = w_wr.intr_status ? hba_dbus[NUM_PINS-1:0] : '0;

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      r_intr_status <= '0;
    end else begin
      r_intr_status <= (r_intr_status & ~w_status_clr) | w_status_set;
    end
  end

  assign hba_dbus_slave    = r_dbus_slave;
  assign hba_xferack_slave = r_xferack;
  assign slave_interrupt   = |(r_intr_status & r_intr_en);
  assign gpio_out_en       = r_dir;
  assign gpio_out_sig      = r_pins;

endmodule
